// File: rtl/pca_pkg.sv
// Shared types and helpers for the PCA matrix pipeline.
package pca_pkg;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILL, BANK_FULL} bank_state_t;

    // Bit offset of element (r,c) in a row-major flattened N x N matrix of W-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matrix_pingpong_buffer_if.sv
// Row-in / matrix-out handshake bundle for the ping-pong matrix buffer.
interface matrix_pingpong_buffer_if #(
    parameter int unsigned MATRIX_SIZE = 4,
    parameter int unsigned DATA_WIDTH  = 8
);
    localparam int unsigned ROW_W = MATRIX_SIZE * DATA_WIDTH;
    localparam int unsigned MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

    logic [ROW_W-1:0] row_in;
    logic             row_valid;
    logic             row_ready;
    logic             transpose;
    logic [MAT_W-1:0] mat_out;
    logic             mat_valid;
    logic             mat_ready;
    logic [1:0]       occupancy;

    modport master (
        output row_in, row_valid, transpose, mat_ready,
        input  row_ready, mat_out, mat_valid, occupancy
    );

    modport slave (
        input  row_in, row_valid, transpose, mat_ready,
        output row_ready, mat_out, mat_valid, occupancy
    );

endinterface

// File: rtl/matrix_transpose.sv
// Purely combinational transpose of a flattened square matrix.
module matrix_transpose
    import pca_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = 4,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_in,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_out
);
    localparam int unsigned N = MATRIX_SIZE;
    localparam int unsigned W = DATA_WIDTH;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign mat_out[elem_lsb(r, c, N, W) +: W] = mat_in[elem_lsb(c, r, N, W) +: W];
        end
    end

endmodule

// File: rtl/matrix_pingpong_buffer.sv
// Two-bank matrix store: one bank fills row by row while the other is presented whole.
module matrix_pingpong_buffer
    import pca_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE = 4,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    matrix_pingpong_buffer_if.slave bus
);
    localparam int unsigned N     = MATRIX_SIZE;
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned ROW_W = N * W;
    localparam int unsigned MAT_W = N * N * W;
    localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;

    logic [MAT_W-1:0] r_bank [2];
    bank_state_t      r_state [2];
    logic             r_wsel;
    logic             r_rsel;
    logic [CW-1:0]    r_row_cnt;
    logic [1:0]       r_tflag;

    bank_state_t      w_state_nxt [2];
    logic             w_wsel_nxt;
    logic             w_rsel_nxt;
    logic [CW-1:0]    w_row_cnt_nxt;
    logic [1:0]       w_tflag_nxt;

    logic             w_row_ready;
    logic             w_mat_valid;
    logic             w_wr;
    logic             w_rd;
    logic             w_last;
    logic [MAT_W-1:0] w_rd_bank;
    logic [MAT_W-1:0] w_rd_trans;

    assign w_row_ready = (r_state[r_wsel] != BANK_FULL);
    assign w_mat_valid = (r_state[r_rsel] == BANK_FULL);
    assign w_wr        = bus.row_valid & w_row_ready;
    assign w_rd        = w_mat_valid & bus.mat_ready;
    assign w_last      = (r_row_cnt == CW'(N - 1));

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_wsel     <= 1'b0;
            r_rsel     <= 1'b0;
            r_row_cnt  <= '0;
            r_tflag    <= '0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_wsel     <= w_wsel_nxt;
            r_rsel     <= w_rsel_nxt;
            r_row_cnt  <= w_row_cnt_nxt;
            r_tflag    <= w_tflag_nxt;
        end
    end

    // Next-state: write and read sides always touch different banks, so both may fire together.
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        w_wsel_nxt     = r_wsel;
        w_rsel_nxt     = r_rsel;
        w_row_cnt_nxt  = r_row_cnt;
        w_tflag_nxt    = r_tflag;
        if (flush) begin
            w_state_nxt[0] = BANK_EMPTY;
            w_state_nxt[1] = BANK_EMPTY;
            w_wsel_nxt     = 1'b0;
            w_rsel_nxt     = 1'b0;
            w_row_cnt_nxt  = '0;
            w_tflag_nxt    = '0;
        end else begin
            if (w_wr) begin
                if (r_row_cnt == '0) begin
                    w_tflag_nxt[r_wsel] = bus.transpose;
                end
                if (w_last) begin
                    w_state_nxt[r_wsel] = BANK_FULL;
                    w_row_cnt_nxt       = '0;
                    w_wsel_nxt          = ~r_wsel;
                end else begin
                    w_state_nxt[r_wsel] = BANK_FILL;
                    w_row_cnt_nxt       = r_row_cnt + CW'(1);
                end
            end
            if (w_rd) begin
                w_state_nxt[r_rsel] = BANK_EMPTY;
                w_rsel_nxt          = ~r_rsel;
            end
        end
    end

    // Bank storage; flush leaves contents in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_wr && !flush) begin
            r_bank[r_wsel][32'(r_row_cnt) * ROW_W +: ROW_W] <= bus.row_in;
        end
    end

    assign w_rd_bank = r_bank[r_rsel];

    matrix_transpose #(
        .MATRIX_SIZE (N),
        .DATA_WIDTH  (W)
    ) u_transpose (
        .mat_in  (w_rd_bank),
        .mat_out (w_rd_trans)
    );

    assign bus.row_ready = w_row_ready;
    assign bus.mat_valid = w_mat_valid;
    assign bus.mat_out   = r_tflag[r_rsel] ? w_rd_trans : w_rd_bank;
    assign bus.occupancy = 2'(r_state[0] == BANK_FULL) + 2'(r_state[1] == BANK_FULL);

endmodule

// File: tb/tb_matrix_pingpong_buffer.sv
// Directed bench for matrix_pingpong_buffer at N=4, W=8.
module tb_matrix_pingpong_buffer;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_pass;
    int   n_total;

    logic [31:0]  rows_a [4];
    logic [31:0]  rows_b [4];
    logic [127:0] mat_a, mat_at, mat_b, mat_bt;

    int           pulses;
    int           p_idx [2];
    logic [127:0] p_dat [2];

    matrix_pingpong_buffer_if #(.MATRIX_SIZE(4), .DATA_WIDTH(8)) bus ();

    matrix_pingpong_buffer #(.MATRIX_SIZE(4), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [31:0] data, input logic tr);
        bus.row_in    = data;
        bus.row_valid = 1'b1;
        bus.transpose = tr;
        step();
        bus.row_valid = 1'b0;
    endtask

    task automatic pop();
        bus.mat_ready = 1'b1;
        step();
        bus.mat_ready = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        pulses  = 0;
        p_idx[0] = -1; p_idx[1] = -1;
        p_dat[0] = '0; p_dat[1] = '0;
        rows_a[0] = 32'h03020100; rows_a[1] = 32'h07060504;
        rows_a[2] = 32'h0B0A0908; rows_a[3] = 32'h0F0E0D0C;
        rows_b[0] = 32'h13121110; rows_b[1] = 32'h17161514;
        rows_b[2] = 32'h1B1A1918; rows_b[3] = 32'h1F1E1D1C;
        mat_a  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        mat_at = 128'h0F0B0703_0E0A0602_0D090501_0C080400;
        mat_b  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
        mat_bt = 128'h1F1B1713_1E1A1612_1D191511_1C181410;

        bus.row_in    = '0;
        bus.row_valid = 1'b0;
        bus.transpose = 1'b0;
        bus.mat_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_row_ready", 128'(bus.row_ready), 128'd1);
        check("rst_mat_valid", 128'(bus.mat_valid), 128'd0);
        check("rst_mat_out",   bus.mat_out,         128'd0);
        check("rst_occupancy", 128'(bus.occupancy), 128'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: single matrix, no transpose, consumer always ready
        bus.mat_ready = 1'b1;
        send_row(rows_a[0], 1'b0);
        send_row(rows_a[1], 1'b0);
        send_row(rows_a[2], 1'b0);
        check("t1_empty_no_valid", 128'(bus.mat_valid), 128'd0);
        send_row(rows_a[3], 1'b0);
        check("t1_mat_valid", 128'(bus.mat_valid), 128'd1);
        check("t1_mat_out",   bus.mat_out,         mat_a);
        check("t1_occupancy", 128'(bus.occupancy), 128'd1);
        step();
        bus.mat_ready = 1'b0;
        check("t1_popped_valid", 128'(bus.mat_valid), 128'd0);
        check("t1_popped_occ",   128'(bus.occupancy), 128'd0);

        // 2: transpose latched at row 0 only
        send_row(rows_a[0], 1'b1);
        send_row(rows_a[1], 1'b0);
        send_row(rows_a[2], 1'b0);
        send_row(rows_a[3], 1'b0);
        check("t2_mat_valid", 128'(bus.mat_valid), 128'd1);
        check("t2_mat_out",   bus.mat_out,         mat_at);
        pop();
        check("t2_popped_occ", 128'(bus.occupancy), 128'd0);

        // 3: backpressure with both banks full
        for (int i = 0; i < 4; i++) send_row(rows_a[i], 1'b0);
        for (int i = 0; i < 4; i++) send_row(rows_b[i], 1'b0);
        check("t3_occ_full",  128'(bus.occupancy), 128'd2);
        check("t3_row_ready", 128'(bus.row_ready), 128'd0);
        check("t3_out_a",     bus.mat_out,         mat_a);
        bus.row_in    = 32'hDEADBEEF;
        bus.row_valid = 1'b1;
        step();
        check("t3_held_occ",   128'(bus.occupancy), 128'd2);
        check("t3_held_out_a", bus.mat_out,         mat_a);
        bus.mat_ready = 1'b1;
        step();
        bus.mat_ready = 1'b0;
        check("t3_ready_back", 128'(bus.row_ready), 128'd1);
        bus.row_valid = 1'b0;
        check("t3_out_b",   bus.mat_out,         mat_b);
        check("t3_valid_b", 128'(bus.mat_valid), 128'd1);
        check("t3_occ_one", 128'(bus.occupancy), 128'd1);
        pop();
        check("t3_occ_zero", 128'(bus.occupancy), 128'd0);

        // 4: continuous streaming with consumer always ready
        bus.mat_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                bus.row_in    = (k < 4) ? rows_a[k] : rows_b[k-4];
                bus.row_valid = 1'b1;
                bus.transpose = 1'b0;
                check("t4_row_ready", 128'(bus.row_ready), 128'd1);
            end else begin
                bus.row_valid = 1'b0;
            end
            step();
            check("t4_occ_not2", 128'(bus.occupancy != 2'd2), 128'd1);
            if (bus.mat_valid) begin
                if (pulses < 2) begin
                    p_idx[pulses] = k;
                    p_dat[pulses] = bus.mat_out;
                end
                pulses++;
            end
        end
        bus.row_valid = 1'b0;
        bus.mat_ready = 1'b0;
        check("t4_pulses",   128'(pulses),   128'd2);
        check("t4_pulse0_t", 128'(p_idx[0]), 128'd3);
        check("t4_pulse1_t", 128'(p_idx[1]), 128'd7);
        check("t4_pulse0_d", p_dat[0],       mat_a);
        check("t4_pulse1_d", p_dat[1],       mat_b);

        // 5a: asynchronous reset mid-fill
        send_row(rows_a[0], 1'b0);
        send_row(rows_a[1], 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_row_ready", 128'(bus.row_ready), 128'd1);
        check("t5_rst_mat_valid", 128'(bus.mat_valid), 128'd0);
        check("t5_rst_mat_out",   bus.mat_out,         128'd0);
        check("t5_rst_occ",       128'(bus.occupancy), 128'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_row(rows_b[i], 1'b0);
        check("t5_rst_new_valid", 128'(bus.mat_valid), 128'd1);
        check("t5_rst_new_out",   bus.mat_out,         mat_b);
        check("t5_rst_new_occ",   128'(bus.occupancy), 128'd1);
        pop();

        // 5b: flush mid-fill; storage kept, pointers cleared
        send_row(rows_a[0], 1'b1);
        send_row(rows_a[1], 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_fl_occ",       128'(bus.occupancy), 128'd0);
        check("t5_fl_mat_valid", 128'(bus.mat_valid), 128'd0);
        check("t5_fl_row_ready", 128'(bus.row_ready), 128'd1);
        check("t5_fl_kept_out",  bus.mat_out,         mat_b);
        send_row(rows_a[0], 1'b0);
        send_row(rows_a[1], 1'b0);
        send_row(rows_a[2], 1'b0);
        check("t5_fl_partial", 128'(bus.mat_valid), 128'd0);
        send_row(rows_a[3], 1'b0);
        check("t5_fl_new_valid", 128'(bus.mat_valid), 128'd1);
        check("t5_fl_new_out",   bus.mat_out,         mat_a);
        pop();

        // 6: per-bank mode plus simultaneous last-row write and pop
        send_row(rows_a[0], 1'b0);
        send_row(rows_a[1], 1'b1);
        send_row(rows_a[2], 1'b1);
        send_row(rows_a[3], 1'b1);
        check("t6_a_valid", 128'(bus.mat_valid), 128'd1);
        check("t6_a_out",   bus.mat_out,         mat_a);
        send_row(rows_b[0], 1'b1);
        send_row(rows_b[1], 1'b0);
        send_row(rows_b[2], 1'b0);
        check("t6_fill_occ",   128'(bus.occupancy), 128'd1);
        check("t6_fill_ready", 128'(bus.row_ready), 128'd1);
        bus.mat_ready = 1'b1;
        send_row(rows_b[3], 1'b0);
        bus.mat_ready = 1'b0;
        check("t6_sim_occ",   128'(bus.occupancy), 128'd1);
        check("t6_sim_valid", 128'(bus.mat_valid), 128'd1);
        check("t6_b_out",     bus.mat_out,         mat_bt);
        check("t6_sim_ready", 128'(bus.row_ready), 128'd1);
        pop();
        check("t6_end_occ",   128'(bus.occupancy), 128'd0);
        check("t6_end_valid", 128'(bus.mat_valid), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
